regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the superscalar datapath: NRD async
//  read ports, NWR sync write ports, optional write-to-read bypass, hardwired-zero
//  reg 0. Adds a per-register pending scoreboard (set at issue, cleared at
//  writeback) that drives read-port busy flags to the hazard/stall unit.
// PARAMETERS
//  DATA_W   32  register width in bits
//  ADDR_W   5   address width; DEPTH = 2**ADDR_W registers
//  NRD      2   number of read ports
//  NWR      2   number of write ports (port NWR-1 has highest priority)
//  BYPASS   1   1: same-cycle write data forwarded to reads; 0: array only
//  ZERO_REG 1   1: reg 0 reads 0, ignores writes and issues
// PORTS
//  Clock     in   1              clock, rising edge
//  nReset    in   1              reset, asynchronous, active-low
//  WrEn      in   NWR            write enable per write port
//  WrAddr    in   NWR x ADDR_W   write address per port
//  WrData    in   NWR x DATA_W   write data per port
//  RAddr     in   NRD x ADDR_W   read address per port
//  RData     out  NRD x DATA_W   read data per port (combinational)
//  RBusy     out  NRD            read reg has pending writeback (combinational)
//  IssueEn   in   1              reserve IssueAddr as pending
//  IssueAddr in   ADDR_W         destination reg being issued
//  Flush     in   1              clear all pending bits
//  PendCount out  ADDR_W+1       number of regs currently pending (registered)
// BEHAVIOUR
//  Reset: all DEPTH regs <= 0, all pending <= 0, PendCount <= 0. Reset mid-
//   operation discards in-flight writes/issues that edge; RData returns 0 and
//   RBusy returns 0 while nReset is low (bypass ignored in reset).
//  Write: at posedge, mem[WrAddr[p]] <= WrData[p] for each WrEn[p]. Same addr on
//   several ports: highest-index port wins. Addr 0 dropped when ZERO_REG.
//  Read: RData[i] = 0 if ZERO_REG && RAddr[i]==0; else if BYPASS and any enabled
//   WrAddr[p]==RAddr[i] -> WrData of highest such p; else mem[RAddr[i]]. Zero
//   latency when BYPASS, one cycle (next edge) otherwise.
//  Scoreboard, next-state per reg r, applied in order:
//   1) Flush -> pending[r]=0; 2) any WrEn to r -> pending[r]=0;
//   3) IssueEn && IssueAddr==r -> pending[r]=1 (issue is newer; wins over
//      write and Flush same cycle). Issue to reg 0 ignored when ZERO_REG.
//   Issue to an already-pending reg: stays 1 (no nesting count).
//  RBusy[i] = pending[RAddr[i]] && !(BYPASS && enabled write to RAddr[i] this
//   cycle); always 0 for reg 0 when ZERO_REG.
//  PendCount = popcount(pending) registered, updated same edge as pending;
//   range 0..DEPTH, never wraps.
//  Assertion (sim only, after reset): mem[0]==0 when ZERO_REG; PendCount<=DEPTH.
// STRUCTURE
//  Package regfile_pkg: default DATA_W/ADDR_W, typedef reg_addr_t, reg_data_t,
//   function popcount. Shared with decode and hazard unit.
//  Sub-module reg_scoreboard: pending vector, issue/write/flush update,
//   PendCount counter, RBusy lookup. regfile_mp holds array, write priority,
//   read mux/bypass and instantiates reg_scoreboard.
// TESTING
//  T1 reset: load regs 1..31 with 0xA5A5_0000+n, pulse nReset low mid-cycle ->
//     all RData 0, PendCount 0 immediately and after release.
//  T2 zero reg: WrEn[0], WrAddr 0, WrData 0xDEADBEEF; IssueAddr 0 -> RAddr 0
//     reads 0, RBusy 0, PendCount unchanged.
//  T3 write conflict: port0 r5=0x11, port1 r5=0x22 same edge -> RData(r5)=0x22
//     (bypass same cycle when BYPASS=1, next cycle when BYPASS=0).
//  T4 scoreboard: issue r7 -> next cycle RBusy=1, PendCount=1; write r7=0x77 ->
//     same cycle RBusy=0 with RData=0x77 (BYPASS=1), PendCount=0 next edge.
//  T5 simultaneous: issue r9 + write r9 + Flush with r3,r4 pending -> after edge
//     pending={r9}, PendCount=1, mem[9] updated.
//  T6 saturate: issue r1..r31 on successive cycles -> PendCount=31; Flush -> 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Package regfile_pkg
// Shared register-file definitions used by the register file, decode and the
// hazard unit: default widths, register address/data types and a popcount
// helper.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    // Widest pending vector popcount accepts; narrower vectors are zero-extended.
    localparam int unsigned MAX_DEPTH  = 256;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

    function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Module reg_scoreboard
// Per-register pending-writeback tracker for regfile_mp.
//   Clock, nReset       clock (rising edge), async active-low reset
//   WrEn/WrAddr         writeback ports; a write clears the target's pending bit
//   IssueEn/IssueAddr   destination being issued; sets its pending bit
//   Flush               clears every pending bit
//   RAddr               read-port addresses to look up
//   RBusy               per read port: register has a pending writeback
//   PendCount           registered number of pending registers
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                         Clock,
    input  logic                         nReset,
    input  logic [NWR-1:0]               WrEn,
    input  logic [NWR-1:0][ADDR_W-1:0]   WrAddr,
    input  logic                         IssueEn,
    input  logic [ADDR_W-1:0]            IssueAddr,
    input  logic                         Flush,
    input  logic [NRD-1:0][ADDR_W-1:0]   RAddr,
    output logic [NRD-1:0]               RBusy,
    output logic [ADDR_W:0]              PendCount
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0]     pending;
    logic [DEPTH-1:0]     pend_next;
    logic [MAX_DEPTH-1:0] pend_ext;
    logic [ADDR_W:0]      count_next;

    // Flush, then writeback clears, then issue sets: the issue is the newest
    // event so it survives a same-cycle write or flush of the same register.
    always_comb begin
        pend_next = pending;
        if (Flush) begin
            pend_next = '0;
        end
        for (int unsigned p = 0; p < NWR; p++) begin
            if (WrEn[p]) begin
                pend_next[WrAddr[p]] = 1'b0;
            end
        end
        if (IssueEn && !(ZERO_REG != 0 && IssueAddr == '0)) begin
            pend_next[IssueAddr] = 1'b1;
        end
    end

    always_comb begin
        pend_ext             = '0;
        pend_ext[DEPTH-1:0]  = pend_next;
        count_next           = (ADDR_W+1)'(popcount(pend_ext));
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pending   <= '0;
            PendCount <= '0;
        end else begin
            pending   <= pend_next;
            PendCount <= count_next;
        end
    end

    // A register being written this cycle is already readable through the
    // bypass, so it is not reported busy.
    always_comb begin
        for (int unsigned i = 0; i < NRD; i++) begin
            logic wr_hit;
            wr_hit = 1'b0;
            for (int unsigned p = 0; p < NWR; p++) begin
                if (WrEn[p] && WrAddr[p] == RAddr[i]) begin
                    wr_hit = 1'b1;
                end
            end
            RBusy[i] = nReset && pending[RAddr[i]]
                       && !(BYPASS != 0 && wr_hit)
                       && !(ZERO_REG != 0 && RAddr[i] == '0);
        end
    end

    a_pend_range: assert property (@(posedge Clock) disable iff (!nReset)
        PendCount <= (ADDR_W+1)'(DEPTH));

endmodule

// File: rtl/regfile_mp.sv
// Module regfile_mp
// Multi-port register file: NRD asynchronous read ports, NWR synchronous write
// ports (highest-index port wins on address conflicts), optional same-cycle
// write-to-read bypass, optional hardwired-zero register 0, plus a pending
// scoreboard feeding the hazard unit.
//   Clock, nReset            clock (rising edge), async active-low reset
//   WrEn/WrAddr/WrData       write ports
//   RAddr/RData              read ports (combinational)
//   RBusy                    read register has a pending writeback
//   IssueEn/IssueAddr/Flush  scoreboard control
//   PendCount                registered number of pending registers
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                         Clock,
    input  logic                         nReset,
    input  logic [NWR-1:0]               WrEn,
    input  logic [NWR-1:0][ADDR_W-1:0]   WrAddr,
    input  logic [NWR-1:0][DATA_W-1:0]   WrData,
    input  logic [NRD-1:0][ADDR_W-1:0]   RAddr,
    output logic [NRD-1:0][DATA_W-1:0]   RData,
    output logic [NRD-1:0]               RBusy,
    input  logic                         IssueEn,
    input  logic [ADDR_W-1:0]            IssueAddr,
    input  logic                         Flush,
    output logic [ADDR_W:0]              PendCount
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem;

    // Later ports overwrite earlier ones within the loop, giving the
    // highest-index port priority.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            mem <= '0;
        end else begin
            for (int unsigned p = 0; p < NWR; p++) begin
                if (WrEn[p] && !(ZERO_REG != 0 && WrAddr[p] == '0)) begin
                    mem[WrAddr[p]] <= WrData[p];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NRD; i++) begin
            RData[i] = mem[RAddr[i]];
            if (BYPASS != 0) begin
                for (int unsigned p = 0; p < NWR; p++) begin
                    if (WrEn[p] && WrAddr[p] == RAddr[i]) begin
                        RData[i] = WrData[p];
                    end
                end
            end
            if ((ZERO_REG != 0 && RAddr[i] == '0) || !nReset) begin
                RData[i] = '0;
            end
        end
    end

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NRD      (NRD),
        .NWR      (NWR),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .Clock     (Clock),
        .nReset    (nReset),
        .WrEn      (WrEn),
        .WrAddr    (WrAddr),
        .IssueEn   (IssueEn),
        .IssueAddr (IssueAddr),
        .Flush     (Flush),
        .RAddr     (RAddr),
        .RBusy     (RBusy),
        .PendCount (PendCount)
    );

    a_zero_reg: assert property (@(posedge Clock) disable iff (!nReset)
        (ZERO_REG == 0) || (mem[0] == '0));

endmodule
